// File: rtl/riscv_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: default widths,
// reset PC, the fetch-entry record, opcode constants and a PC helper.
// Optional feature macro used by importers: RISCV_FETCH_MISALIGN_CHECK_EN.
package riscv_fetch_unit_pkg;

    localparam int unsigned FETCH_XLEN     = 32;
    localparam int unsigned FETCH_INSTR_W  = 32;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    // Record held per prefetch-queue entry (default widths)
    typedef struct packed {
        logic [FETCH_XLEN-1:0]    pc;
        logic [FETCH_INSTR_W-1:0] instr;
        logic                     misalign;
    } fetch_entry_t;

    // Control-transfer opcodes decode uses to produce redirects
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;

    // Instruction fetch addresses must be word aligned
    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return pc_lo != 2'b00;
    endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Synchronous prefetch queue: DEPTH entries, push/pop/flush, occupancy count.
// Head outputs come straight from the storage registers, so a word pushed in
// cycle N is visible at the head in cycle N+1.
module riscv_fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // Flush wins over both push and pop; full/empty guards keep state sane
    assign push_ok = push && !flush && (count_q != FULL);
    assign pop_ok  = pop && !flush && (count_q != '0);

    // Pointer and occupancy next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_valid = (count_q != '0);
    assign head_data  = mem_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues credit-limited pipelined
// requests, queues in-order responses with their PCs and hands them to
// decode. Redirects flush the queue and arrange for in-flight responses to be
// discarded. Optional macro RISCV_FETCH_MISALIGN_CHECK_EN adds a per-entry
// misalign flag and the instr_misalign port.
module riscv_fetch_unit
    import riscv_fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN     = FETCH_XLEN,
    parameter int unsigned     INSTR_W  = FETCH_INSTR_W,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC),
    parameter int unsigned     DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [XLEN-1:0]    instr_pc,
`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
    output logic               instr_misalign,
`endif
    output logic               busy
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(DEPTH);
`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
    localparam int unsigned ENTRY_W = XLEN + INSTR_W + 1;
`else
    localparam int unsigned ENTRY_W = XLEN + INSTR_W;
`endif

    logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]    rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   discard_q, discard_d;
    logic [CNT_W-1:0]   count;
    logic [CNT_W:0]     credit_used;
    logic               req_fire;
    logic               rsp_ok;
    logic               push;
    logic               pop;
    logic               head_valid;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;

    // Queued words plus words in flight may never exceed the queue size,
    // which is what makes overflow impossible without backpressuring memory
    assign credit_used    = {1'b0, count} + {1'b0, outstanding_q};
    assign imem_req_valid = !redirect_valid && (credit_used < CREDITS);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored
    assign rsp_ok = imem_rsp_valid && (outstanding_q != '0);
    assign push   = rsp_ok && (discard_q == '0) && !redirect_valid;
    assign pop    = head_valid && instr_ready && !redirect_valid;

`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
    assign push_entry = {rsp_pc_q, imem_rsp_data, pc_misaligned(rsp_pc_q[1:0])};
`else
    assign push_entry = {rsp_pc_q, imem_rsp_data};
`endif

    // PC and in-flight bookkeeping next state
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;

        // No request fires in a redirect cycle, so this also covers redirects
        unique case ({req_fire, rsp_ok})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            // Everything still in flight after this cycle is stale
            discard_d  = outstanding_q - CNT_W'(rsp_ok);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (push)     rsp_pc_d   = rsp_pc_q + XLEN'(4);
            if (rsp_ok && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
        end
    end

    // PC and counter registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    riscv_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (redirect_valid),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .head_valid (head_valid),
        .head_data  (head_entry),
        .count      (count)
    );

    assign instr_valid = head_valid;
    assign busy        = (outstanding_q != '0);

`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
    logic head_misalign;
    assign {instr_pc, instr_data, head_misalign} = head_entry;
    // Storage is unreset, so qualify the flag with the valid bit
    assign instr_misalign = head_valid && head_misalign;
`else
    assign {instr_pc, instr_data} = head_entry;
`endif

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Scoreboard bench for riscv_fetch_unit: an in-order memory model with
// configurable latency serves requests; non-stale responses push expected
// {pc, instr} entries that are popped and compared on each decode handshake.
module tb_riscv_fetch_unit;

    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
    logic        instr_misalign;
`endif
    logic        busy;

    riscv_fetch_unit #(
        .XLEN     (32),
        .INSTR_W  (32),
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
        .instr_misalign (instr_misalign),
`endif
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;      // address the DUT actually requested
        logic [31:0] exp_addr;  // address the model says it should have been
        int          gen;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    mreq_t       mem_q[$];
    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          gen = 0;
    int          lat = 1;
    int          mem_mode = 0;  // 0: always ready, 1: random
    int          dec_mode = 1;  // 0: hold low, 1: high, 2: random
    logic [31:0] next_addr = RESET_PC;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Called at posedge+1: drive one cycle, score it at negedge, advance
    task automatic step(input logic redir, input logic [31:0] tgt);
        mreq_t m;
        exp_t  e;
        redirect_valid = redir;
        redirect_pc    = tgt;
        imem_req_ready = (mem_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        instr_ready    = (dec_mode == 0) ? 1'b0 :
                         (dec_mode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end

        @(negedge clk);
        check("busy", 64'(busy), 64'(mem_q.size() != 0));
        check("req_valid", 64'(imem_req_valid),
              64'(!redir && (exp_q.size() + mem_q.size() < DEPTH)));
        check("instr_valid", 64'(instr_valid), 64'(exp_q.size() != 0));

        if (instr_valid && instr_ready && !redir && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("instr_pc", 64'(instr_pc), 64'(e.pc));
            check("instr_data", 64'(instr_data), 64'(e.data));
`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
            check("instr_misalign", 64'(instr_misalign), 64'(e.pc[1:0] != 2'b00));
`endif
        end
        if (imem_rsp_valid) begin
            m = mem_q.pop_front();
            if (!redir && m.gen == gen) exp_q.push_back('{pc: m.exp_addr, data: mem_word(m.exp_addr)});
        end
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", 64'(imem_req_addr), 64'(next_addr));
            mem_q.push_back('{addr: imem_req_addr, exp_addr: next_addr, gen: gen, due: cyc + lat});
            next_addr = next_addr + 32'd4;
        end
        if (redir) begin
            gen++;
            exp_q.delete();
            next_addr = tgt;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0);
    endtask

    // Asynchronous reset; the memory model forgets everything in flight
    task automatic do_reset();
        rstn           = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
        #3;
        check("rst_instr_valid", 64'(instr_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
        check("rst_misalign", 64'(instr_misalign), 64'(0));
`endif
        mem_q.delete();
        exp_q.delete();
        gen++;
        next_addr = RESET_PC;
        cyc = 0;
        @(posedge clk);
        #1;
        check("rst_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
        rstn = 1'b1;
    endtask

    initial begin
        logic [31:0] tgt;

        // Streaming with a 1-cycle memory and decode always ready
        do_reset();
        lat = 1; mem_mode = 0; dec_mode = 1;
        run(2);
        check("first_instr_valid", 64'(instr_valid), 64'(1));
        check("first_instr_pc", 64'(instr_pc), 64'(RESET_PC));
        run(18);

        // Decode stalled: credits cap in-flight plus queued at DEPTH
        dec_mode = 0;
        run(10);
        dec_mode = 1;
        run(10);

        // 3-cycle memory, redirect while three requests are outstanding
        lat = 3;
        for (int i = 0; i < 20 && mem_q.size() != 3; i++) step(1'b0, 32'h0);
        check("pre_redirect_busy", 64'(busy), 64'(1));
        step(1'b1, 32'h100);
        run(15);

        // Redirect coinciding with a response and a pop
        lat = 1;
        run(6);
        step(1'b1, 32'h200);
        check("flush_empty", 64'(instr_valid), 64'(0));
        run(8);

        // PC wraps past the top of the address space
        step(1'b1, 32'hFFFF_FFF8);
        run(10);

        // Misaligned redirect target
        step(1'b1, 32'h102);
        run(8);

        // Random backpressure, latency and redirects
        mem_mode = 1; dec_mode = 2;
        for (int i = 0; i < 400; i++) begin
            lat = $urandom_range(1, 4);
            if ($urandom_range(0, 19) == 0) begin
                tgt = $urandom & ~32'h3;
                if ($urandom_range(0, 3) == 0) tgt[1] = 1'b1;
                step(1'b1, tgt);
            end else begin
                step(1'b0, 32'h0);
            end
        end

        // Reset in the middle of traffic, then resume
        do_reset();
        mem_mode = 0; dec_mode = 1; lat = 2;
        run(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_fetch_unit.md
# riscv_fetch_unit

Parametrised instruction-fetch front end for the RISC-V core: owns the program counter, issues pipelined requests to a latency-tolerant instruction memory, buffers returned words with their PCs in a prefetch queue, and hands them to decode over a valid/ready handshake. Branch/jump redirects flush the queue and silently discard responses still in flight.

## Interface
- XLEN, 32, address/PC width
- INSTR_W, 32, instruction width
- RESET_PC, 0, PC loaded on reset
- DEPTH, 4, prefetch queue entries and max in-flight requests (power of two, ≥2)

- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- redirect_valid  in  1  redirect fetch this cycle
- redirect_pc  in  XLEN  redirect target
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address
- imem_rsp_valid  in  1  in-order response valid
- imem_rsp_data  in  INSTR_W  response word
- instr_valid  out  1  queue head valid
- instr_ready  in  1  decode consumes head
- instr_data  out  INSTR_W  head instruction
- instr_pc  out  XLEN  head PC
- instr_misalign  out  1  head PC not 4-byte aligned (macro only)
- busy  out  1  requests outstanding

## Operation
- Registers: fetch_pc (next request address), rsp_pc (PC of next accepted response), outstanding and discard counters ($clog2(DEPTH+1) bits), queue count.
- imem_req_valid = !redirect_valid && (count + outstanding < DEPTH); imem_req_addr = fetch_pc.
- Request accepted (valid && ready): fetch_pc += 4 (mod 2^XLEN, wraps), outstanding++.
- Response: outstanding--. If discard > 0: discard--, word dropped. Else push {rsp_pc, data}; rsp_pc += 4.
- Pop when instr_valid && instr_ready. Push and pop in the same cycle both occur; count unchanged.
- Credit rule guarantees no overflow; response with outstanding == 0 is a protocol violation: ignored, counters unchanged.
- Redirect cycle: queue flushed (pop ignored), fetch_pc ← redirect_pc, rsp_pc ← redirect_pc, no request issued, same-cycle response dropped, discard ← outstanding − imem_rsp_valid.
- busy = (outstanding != 0).

## Timing
- Reset values: fetch_pc = rsp_pc = RESET_PC, counters 0, instr_valid 0, busy 0, instr_misalign 0; imem_req_valid 1 in first cycle after reset release (addr RESET_PC).
- Request accepted cycle N, response earliest N+1, instr_valid earliest N+2 (registered queue).
- 1-cycle memory, instr_ready held high: one instruction per cycle sustained.
- First post-redirect request in cycle R+1 at redirect_pc.
- Reset mid-operation: all state cleared immediately; environment must not deliver pre-reset responses after release.

## Configuration
- RISCV_FETCH_MISALIGN_CHECK_EN defined: queue entry carries misalign bit = pc[1:0] != 0; instr_misalign reflects head; fetch continues normally (decode raises the exception).
- Undefined: no misalign bit stored, instr_misalign port absent; low two PC bits passed through unchecked.

## Structure
- Shared package/defines: XLEN, INSTR_W, RESET_PC default, fetch-entry typedef {pc, instr, misalign}, opcode constants.
- Sub-module riscv_fetch_fifo: synchronous DEPTH-entry FIFO with push, pop, flush, count, registered head outputs.

## Test plan
- Reset release, 1-cycle memory, ready high → requests 0x0,0x4,0x8…; instr_pc 0x0 at cycle 2, one instruction/cycle thereafter.
- instr_ready low, memory always ready → exactly DEPTH=4 requests issued then imem_req_valid 0; raising ready → instructions 0x0..0xC in order, fetch resumes at 0x10.
- 3-cycle memory latency, redirect to 0x100 with 3 outstanding → 3 responses dropped, next instr_pc 0x100, busy falls after last stale response.
- Redirect same cycle as response and pop → queue empty next cycle, discard = outstanding−1, no 0x… stale word delivered.
- fetch_pc at 0xFFFFFFFC → next request 0x00000000.
- With macro, redirect to 0x102 → instr_misalign 1 with instr_pc 0x102; without macro, port absent, pc 0x102 delivered.
